// File: rtl/seg7_scan_bcd.sv
// seg7_scan_bcd: binary value -> BCD (sequential shift-add-3) -> multiplexed
// active-low 7-segment display with optional leading-zero blanking and an
// overflow dash pattern. VAL_W is expected to be at most 64 bits.
module seg7_scan_bcd #(
  parameter int DIGITS   = 2,
  parameter int VAL_W    = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [0:6]        seg,
  output logic [DIGITS-1:0] an
);

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  // Active-high a..g pattern; nibble codes 10-15 map to all-off (blank).
  function automatic logic [0:6] seg7_decode(input logic [3:0] n);
    logic [0:6] s;
    case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  localparam int          BW    = 4 * DIGITS;
  localparam int          CW    = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int          DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int          IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAXV  = pow10_m1(DIGITS);
  localparam logic [0:6]  SEG_BLANK = 7'b1111111;
  localparam logic [0:6]  SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  logic [VAL_W-1:0]   r_shift;
  logic [BW-1:0]      r_bcd;
  logic [CW-1:0]      r_cnt;
  logic               r_ovf_next;
  logic [BW-1:0]      r_disp;
  logic               r_overflow;
  logic               r_disp_valid;
  logic               r_busy;

  logic [DW-1:0]      r_div;
  logic [IW-1:0]      r_idx;
  logic [DIGITS-1:0]  r_an;
  logic [0:6]         r_seg;

  logic               w_ovf;
  logic [BW-1:0]      w_bcd_adj;
  logic [BW+VAL_W-1:0] w_cat;
  logic               w_div_wrap;
  logic [IW-1:0]      w_idx_next;
  logic [DIGITS-1:0]  w_an_next;
  logic [DIGITS-1:0]  w_lz;
  logic [3:0]         w_nib;
  logic               w_lz_sel;
  logic [0:6]         w_seg_next;

  assign w_ovf = (64'(value) > MAXV);

  // Add-3 correction on every nibble >= 5 ahead of the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Top bit of the shifted concatenation falls off the end.
  assign w_cat = {w_bcd_adj, r_shift} << 1;

  // Conversion FSM: capture, VAL_W shift steps, then publish to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf_next   <= 1'b0;
      r_disp       <= '0;
      r_overflow   <= 1'b0;
      r_disp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift    <= value;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= w_ovf;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd   <= w_cat[BW+VAL_W-1:VAL_W];
          r_shift <= w_cat[VAL_W-1:0];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(VAL_W - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_disp       <= r_bcd;
          r_overflow   <= r_ovf_next;
          r_disp_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_div_wrap = (r_div == DW'(SCAN_DIV - 1));

  // Next scan index; seg and an are both decoded from it so they switch together.
  always_comb begin
    w_idx_next = r_idx;
    if (w_div_wrap) begin
      if (r_idx == IW'(DIGITS - 1)) w_idx_next = '0;
      else                          w_idx_next = r_idx + 1'b1;
    end
    w_an_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == w_idx_next) w_an_next[k] = 1'b0;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic w_run;
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_run   = w_run & (r_disp[4*k +: 4] == 4'd0);
      w_lz[k] = w_run;
    end
  end

  // Select and encode the digit that becomes active on the next edge.
  always_comb begin
    w_nib    = 4'd0;
    w_lz_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == w_idx_next) begin
        w_nib    = r_disp[4*k +: 4];
        w_lz_sel = w_lz[k];
      end
    end
    if (!r_disp_valid)
      w_seg_next = SEG_BLANK;
    else if (r_overflow)
      w_seg_next = SEG_DASH;
    else if ((BLANK_LZ != 0) && (w_idx_next != '0) && w_lz_sel)
      w_seg_next = SEG_BLANK;
    else
      w_seg_next = ~seg7_decode(w_nib);
  end

  // Scan divider, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      r_idx <= w_idx_next;
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign seg      = r_seg;
  assign an       = r_an;

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Bench for seg7_scan_bcd: three instances (2 digits blanked, 2 digits
// unblanked, 3 digits blanked) share stimulus; accepted loads go into a
// scoreboard queue and are checked when the conversion completes.
module tb_seg7_scan_bcd;
  localparam int VW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [VW-1:0] value = '0;

  logic          busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
  logic [0:6]    seg_a, seg_b, seg_c;
  logic [1:0]    an_a, an_b;
  logic [2:0]    an_c;

  always #5 clk = ~clk;

  seg7_scan_bcd #(.DIGITS(2), .VAL_W(VW), .SCAN_DIV(SD), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));
  seg7_scan_bcd #(.DIGITS(2), .VAL_W(VW), .SCAN_DIV(SD), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));
  seg7_scan_bcd #(.DIGITS(3), .VAL_W(VW), .SCAN_DIV(SD), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_c), .overflow(ovf_c), .seg(seg_c), .an(an_c));

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned t_acc    = 0;
  int          sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:6] code_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  // Reference: what seg must show on digit k of an nd-digit display of v.
  function automatic logic [0:6] exp_seg(input int v, input int nd, input int blz, input int k);
    int p  = 1;
    int pk = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    for (int i = 0; i < k; i++) pk = pk * 10;
    if (v > p - 1) return 7'b1111110;
    if (blz != 0 && k > 0 && v < pk) return 7'b1111111;
    return ~code_of((v / pk) % 10);
  endfunction

  function automatic logic [2:0] an_of(input int i);
    if (i == 0) return {1'b1, an_a};
    if (i == 1) return {1'b1, an_b};
    return an_c;
  endfunction

  function automatic logic [0:6] seg_of(input int i);
    if (i == 0) return seg_a;
    if (i == 1) return seg_b;
    return seg_c;
  endfunction

  // Called at a negedge with rst high; releases it and checks the scan sequence.
  task automatic check_scan();
    logic [1:0] e2;
    logic [2:0] e3;
    rst = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      e2 = ~(2'b01 << ((n / SD) % 2));
      e3 = ~(3'b001 << ((n / SD) % 3));
      chk($sformatf("scan_an_a_%0d", n), an_a, e2);
      chk($sformatf("scan_an_c_%0d", n), an_c, e3);
      chk($sformatf("scan_seg_c_%0d", n), seg_c, 7'b1111111);
      if (n == 1) begin
        chk("rel_seg_a", seg_a, 7'b1111111);
        chk("rel_busy_a", busy_a, 1'b0);
        chk("rel_ovf_a", ovf_a, 1'b0);
      end
    end
  endtask

  // Drive a one-cycle load strobe from a negedge.
  task automatic issue_load(input int v, input bit accept);
    value = VW'(v);
    load  = 1'b1;
    if (accept) sb.push_back(v);
    @(negedge clk);
    load  = 1'b0;
    if (accept) begin
      t_acc = cyc;
      chk("busy_rise", busy_a, 1'b1);
    end
  endtask

  task automatic wait_digit(input int i, input int k);
    logic [2:0] tgt;
    int w = 0;
    tgt = ~(3'b001 << k);
    while (an_of(i) !== tgt && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("an_sel_%0d_%0d", i, k), an_of(i), tgt);
  endtask

  // Wait for the conversion to finish, pop the expected value and check it.
  task automatic collect();
    int w = 0;
    int v = -1;
    int nd;
    int blz;
    while (busy_a && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("busy_len", cyc - t_acc, VW + 1);
    chk("busy_c", busy_c, 1'b0);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) v = sb.pop_front();
    chk($sformatf("ovf_a_%0d", v), ovf_a, (v > 99));
    chk($sformatf("ovf_b_%0d", v), ovf_b, (v > 99));
    chk($sformatf("ovf_c_%0d", v), ovf_c, (v > 999));
    @(negedge clk);
    chk("no_requeue", busy_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nd  = (i == 2) ? 3 : 2;
      blz = (i == 1) ? 0 : 1;
      for (int k = 0; k < nd; k++) begin
        wait_digit(i, k);
        chk($sformatf("seg_%0d_d%0d_v%0d", i, k, v), seg_of(i), exp_seg(v, nd, blz, k));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an_a", an_a, 2'b11);
    chk("rst_seg_a", seg_a, 7'b1111111);
    check_scan();

    issue_load(7, 1);   collect();
    issue_load(205, 1); collect();
    issue_load(100, 1); collect();
    issue_load(99, 1);  collect();
    issue_load(100, 1); collect();

    issue_load(42, 1);
    repeat (2) @(negedge clk);
    issue_load(13, 0);
    collect();

    issue_load(100, 1); collect();
    issue_load(255, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy_a", busy_a, 1'b0);
    chk("mid_rst_busy_c", busy_c, 1'b0);
    chk("mid_rst_ovf_a", ovf_a, 1'b0);
    chk("mid_rst_seg_a", seg_a, 7'b1111111);
    chk("mid_rst_seg_c", seg_c, 7'b1111111);
    chk("mid_rst_an_a", an_a, 2'b11);
    chk("mid_rst_an_c", an_c, 3'b111);
    sb.delete();
    check_scan();

    issue_load(255, 1); collect();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
